// File: rtl/mvu_pkg.sv
// Shared types for the MVU CSR scheduler: CSR offsets, queued command layout, FSM states.
// Pure declarations; no timing or flow control of its own.
package mvu_pkg;

  localparam int SCHED_BMVUA = 3;

  typedef logic [11:0] mvu_csr_t;

  localparam mvu_csr_t CSR_MVUWBASEPTR = 12'h020;
  localparam mvu_csr_t CSR_MVUIBASEPTR = 12'h021;
  localparam mvu_csr_t CSR_MVUOBASEPTR = 12'h022;
  localparam mvu_csr_t CSR_MVUQUANT    = 12'h030;
  localparam mvu_csr_t CSR_MVUCOMMAND  = 12'h040;

  typedef struct packed {
    logic [SCHED_BMVUA-1:0] mvu_id;
    mvu_csr_t               csr;
    logic [31:0]            data;
  } sched_cmd_t;

  localparam int SCHED_CMD_W = $bits(sched_cmd_t);

  typedef enum logic [1:0] {
    SCHED_IDLE,
    SCHED_SETUP,
    SCHED_ACCESS
  } sched_state_t;

endpackage

// File: rtl/mvu_sched_fifo.sv
// Command FIFO with first-word-fall-through head plus a peek at the entry behind it.
// Zero-latency head after push edge; caller must not push when full or pop when empty.
module mvu_sched_fifo
  import mvu_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [SCHED_CMD_W-1:0] push_dat,
  input  logic                   pop,
  output logic [SCHED_CMD_W-1:0] head_dat,
  output logic [SCHED_CMD_W-1:0] next_dat,
  output logic [AW:0]            count
);

  logic [SCHED_CMD_W-1:0] mem [DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;

  assign head_dat = mem[rd_ptr];
  assign next_dat = mem[rd_ptr + AW'(1)];

  // Storage needs no reset: flushing is done by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mvu_csr_scheduler.sv
// Queues MVU CSR writes and issues them as APB writes, holding back writes to busy MVUs (in order).
// SETUP one edge after push, ACCESS the next, pop on pready; cmd_ready drops while the FIFO is full.
module mvu_csr_scheduler
  import mvu_pkg::*;
#(
  parameter int NMVU           = 8,
  parameter int BMVUA          = 3,
  parameter int APB_ADDR_WIDTH = BMVUA + 12,
  parameter int APB_DATA_WIDTH = 32,
  parameter int DEPTH          = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [BMVUA-1:0]          cmd_mvu,
  input  logic [11:0]               cmd_csr,
  input  logic [APB_DATA_WIDTH-1:0] cmd_data,
  input  logic [NMVU-1:0]           mvu_done,
  output logic [NMVU-1:0]           busy,
  output logic [$clog2(DEPTH):0]    fifo_count,
  output logic [APB_ADDR_WIDTH-1:0] paddr,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [APB_DATA_WIDTH-1:0] pwdata,
  input  logic                      pready,
  input  logic                      pslverr,
  output logic                      err,
  input  logic                      err_clr
);

  localparam int CW = $clog2(DEPTH) + 1;

  sched_state_t state, state_nxt;
  sched_cmd_t   push_cmd, head, nxt;
  logic         push, pop;
  logic         head_blocked, nxt_blocked;
  logic [NMVU-1:0]           busy_set;
  logic                      psel_d, penable_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_d;
  logic [APB_DATA_WIDTH-1:0] pwdata_d;

  assign cmd_ready = (fifo_count != CW'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == SCHED_ACCESS) && pready;
  assign pwrite    = 1'b1;

  always_comb begin
    push_cmd        = '0;
    push_cmd.mvu_id = cmd_mvu;
    push_cmd.csr    = cmd_csr;
    push_cmd.data   = cmd_data;
  end

  mvu_sched_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (push_cmd),
    .pop      (pop),
    .head_dat (head),
    .next_dat (nxt),
    .count    (fifo_count)
  );

  always_comb begin
    busy_set = '0;
    if (pop && !pslverr && head.csr == CSR_MVUCOMMAND) busy_set[head.mvu_id] = 1'b1;
  end

  // A command completing now makes its MVU busy this edge, so the entry behind it must see that.
  assign head_blocked = busy[head.mvu_id];
  assign nxt_blocked  = busy[nxt.mvu_id] || busy_set[nxt.mvu_id];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= SCHED_IDLE;
      psel    <= 1'b0;
      penable <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
      busy    <= '0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      psel    <= psel_d;
      penable <= penable_d;
      paddr   <= paddr_d;
      pwdata  <= pwdata_d;
      busy    <= (busy & ~mvu_done) | busy_set;
      err     <= (err & ~err_clr) | (pop && pslverr);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SCHED_IDLE:
        if (fifo_count != '0 && !head_blocked) state_nxt = SCHED_SETUP;
      SCHED_SETUP:
        state_nxt = SCHED_ACCESS;
      SCHED_ACCESS:
        if (pready) begin
          if (fifo_count > CW'(1) && !nxt_blocked) state_nxt = SCHED_SETUP;
          else                                     state_nxt = SCHED_IDLE;
        end
      default:
        state_nxt = SCHED_IDLE;
    endcase
  end

  // Registered outputs are computed for the upcoming state; leaving ACCESS pops, so load the next entry.
  always_comb begin
    psel_d    = (state_nxt != SCHED_IDLE);
    penable_d = (state_nxt == SCHED_ACCESS);
    paddr_d   = paddr;
    pwdata_d  = pwdata;
    if (state_nxt == SCHED_SETUP) begin
      if (state == SCHED_ACCESS) begin
        paddr_d  = APB_ADDR_WIDTH'({nxt.mvu_id, nxt.csr});
        pwdata_d = APB_DATA_WIDTH'(nxt.data);
      end else begin
        paddr_d  = APB_ADDR_WIDTH'({head.mvu_id, head.csr});
        pwdata_d = APB_DATA_WIDTH'(head.data);
      end
    end
  end

endmodule
